// File: rtl/shift_operand_stage_if.sv
// Bundle of the upstream decode handshake, the Rs register-file read port and
// the shifter-side outputs of shift_operand_stage.
interface shift_operand_stage_if #(
  parameter int FULLW      = 32,
  parameter int WIDTH      = 5,
  parameter int SHIFTCODEW = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  imm_flag;
  logic [11:0]           op2;
  logic [FULLW-1:0]      rm_val;
  logic                  cflag;
  logic                  rs_req;
  logic [3:0]            rs_addr;
  logic [FULLW-1:0]      rs_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [FULLW-1:0]      shiftin;
  logic [WIDTH-1:0]      shiftby;
  logic [SHIFTCODEW-1:0] shiftcode;
  logic                  shift_cflag;
  logic                  bypass;
  logic [FULLW-1:0]      bypass_val;
  logic                  bypass_carry;

  modport slave (
    input  in_valid, imm_flag, op2, rm_val, cflag, rs_data, out_ready,
    output in_ready, rs_req, rs_addr, out_valid, shiftin, shiftby, shiftcode,
           shift_cflag, bypass, bypass_val, bypass_carry
  );

  modport master (
    output in_valid, imm_flag, op2, rm_val, cflag, rs_data, out_ready,
    input  in_ready, rs_req, rs_addr, out_valid, shiftin, shiftby, shiftcode,
           shift_cflag, bypass, bypass_val, bypass_carry
  );
endinterface

// File: rtl/shift_operand_stage.sv
// ARM operand2 decode stage in front of the barrel shifter: fetches Rs for
// register shifts and folds shifter-inexpressible cases into a bypass value.
module shift_operand_stage #(
  parameter int FULLW      = 32,
  parameter int WIDTH      = 5,
  parameter int SHIFTCODEW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_operand_stage_if.slave bus
);

  localparam logic [SHIFTCODEW-1:0] SH_LSL = SHIFTCODEW'(0);
  localparam logic [SHIFTCODEW-1:0] SH_LSR = SHIFTCODEW'(1);
  localparam logic [SHIFTCODEW-1:0] SH_ASR = SHIFTCODEW'(2);
  localparam logic [SHIFTCODEW-1:0] SH_ROR = SHIFTCODEW'(3);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    RS_FETCH = 2'd1,
    FULL     = 2'd2
  } state_t;

  state_t                state_q;
  logic [11:4]           op2_q;
  logic [FULLW-1:0]      rm_q;
  logic                  cflag_q;
  logic                  rs_req_q;
  logic [3:0]            rs_addr_q;
  logic [FULLW-1:0]      shiftin_q;
  logic [WIDTH-1:0]      shiftby_q;
  logic [SHIFTCODEW-1:0] shiftcode_q;
  logic                  shift_cflag_q;
  logic                  bypass_q;
  logic [FULLW-1:0]      bypass_val_q;
  logic                  bypass_carry_q;

  logic                  in_ready;
  logic                  accept;
  logic                  reg_form_in;
  logic                  fetch;
  logic                  load_en;
  logic [11:4]           src_op2;
  logic [FULLW-1:0]      src_rm;
  logic                  src_c;
  logic                  src_imm;
  logic [7:0]            amt;
  logic                  amt_big;
  logic                  amt_exact;

  logic [FULLW-1:0]      shiftin_d;
  logic [WIDTH-1:0]      shiftby_d;
  logic [SHIFTCODEW-1:0] shiftcode_d;
  logic                  bypass_d;
  logic [FULLW-1:0]      bypass_val_d;
  logic                  bypass_carry_d;

  logic                  unused_bits;

  assign in_ready    = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready);
  assign accept      = bus.in_valid && in_ready;
  assign reg_form_in = !bus.imm_flag && bus.op2[4];
  assign fetch       = (state_q == RS_FETCH);
  assign load_en     = fetch || (accept && !reg_form_in);

  // In RS_FETCH the operand comes from the latched copy, otherwise straight from the bus.
  assign src_op2 = fetch ? op2_q   : bus.op2[11:4];
  assign src_rm  = fetch ? rm_q    : bus.rm_val;
  assign src_c   = fetch ? cflag_q : bus.cflag;
  assign src_imm = fetch ? 1'b0    : bus.imm_flag;

  assign amt       = bus.rs_data[7:0];
  assign amt_big   = |amt[7:WIDTH];
  assign amt_exact = (amt == 8'(FULLW));

  assign unused_bits = ^{bus.op2[3:0], bus.rs_data[FULLW-1:8]};

  always_comb begin
    shiftin_d      = src_rm;
    shiftby_d      = WIDTH'(src_op2[11:7]);
    shiftcode_d    = SHIFTCODEW'(src_op2[6:5]);
    bypass_d       = 1'b0;
    bypass_val_d   = '0;
    bypass_carry_d = 1'b0;

    if (src_imm) begin
      shiftin_d   = {{(FULLW-8){1'b0}}, src_op2[7:4], bus.op2[3:0]};
      shiftcode_d = SH_ROR;
      shiftby_d   = WIDTH'({src_op2[11:8], 1'b0});
      // Rotate of zero would be taken as RRX by the shifter.
      if (src_op2[11:8] == 4'd0) begin
        bypass_d       = 1'b1;
        bypass_val_d   = {{(FULLW-8){1'b0}}, src_op2[7:4], bus.op2[3:0]};
        bypass_carry_d = src_c;
      end
    end else if (fetch) begin
      shiftby_d = amt[WIDTH-1:0];
      if (amt == 8'd0) begin
        bypass_d       = 1'b1;
        bypass_val_d   = src_rm;
        bypass_carry_d = src_c;
      end else if (amt_big) begin
        case (shiftcode_d)
          SH_LSL: begin
            bypass_d       = 1'b1;
            bypass_carry_d = amt_exact ? src_rm[0] : 1'b0;
          end
          SH_LSR: begin
            bypass_d       = 1'b1;
            bypass_carry_d = amt_exact ? src_rm[FULLW-1] : 1'b0;
          end
          SH_ASR: shiftby_d = '0;
          default: begin
            if (amt[WIDTH-1:0] == '0) begin
              bypass_d       = 1'b1;
              bypass_val_d   = src_rm;
              bypass_carry_d = src_rm[FULLW-1];
            end
          end
        endcase
      end
    end else if ((shiftcode_d == SH_LSL) && (shiftby_d == '0)) begin
      bypass_d       = 1'b1;
      bypass_val_d   = src_rm;
      bypass_carry_d = src_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      op2_q          <= '0;
      rm_q           <= '0;
      cflag_q        <= 1'b0;
      rs_req_q       <= 1'b0;
      rs_addr_q      <= '0;
      shiftin_q      <= '0;
      shiftby_q      <= '0;
      shiftcode_q    <= '0;
      shift_cflag_q  <= 1'b0;
      bypass_q       <= 1'b0;
      bypass_val_q   <= '0;
      bypass_carry_q <= 1'b0;
    end else begin
      rs_req_q <= 1'b0;
      case (state_q)
        EMPTY, FULL: begin
          if (accept) begin
            op2_q   <= bus.op2[11:4];
            rm_q    <= bus.rm_val;
            cflag_q <= bus.cflag;
            if (reg_form_in) begin
              state_q   <= RS_FETCH;
              rs_req_q  <= 1'b1;
              rs_addr_q <= bus.op2[11:8];
            end else begin
              state_q <= FULL;
            end
          end else if ((state_q == FULL) && bus.out_ready) begin
            state_q <= EMPTY;
          end
        end
        RS_FETCH: state_q <= FULL;
        default:  state_q <= EMPTY;
      endcase

      if (load_en) begin
        shiftin_q      <= shiftin_d;
        shiftby_q      <= shiftby_d;
        shiftcode_q    <= shiftcode_d;
        shift_cflag_q  <= src_c;
        bypass_q       <= bypass_d;
        bypass_val_q   <= bypass_val_d;
        bypass_carry_q <= bypass_carry_d;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.rs_req       = rs_req_q;
  assign bus.rs_addr      = rs_addr_q;
  assign bus.out_valid    = (state_q == FULL);
  assign bus.shiftin      = shiftin_q;
  assign bus.shiftby      = shiftby_q;
  assign bus.shiftcode    = shiftcode_q;
  assign bus.shift_cflag  = shift_cflag_q;
  assign bus.bypass       = bypass_q;
  assign bus.bypass_val   = bypass_val_q;
  assign bus.bypass_carry = bypass_carry_q;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage: random and directed operands are
// checked against an operand2 reference model; a monitor pops expected results.
module tb_shift_operand_stage;

  typedef struct packed {
    logic [31:0] shiftin;
    logic [4:0]  shiftby;
    logic [1:0]  code;
    logic        sc;
    logic        byp;
    logic [31:0] bval;
    logic        bc;
    logic        chk_by;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_operand_stage_if bus ();

  shift_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_txn    = 0;
  int          rdy_mode = 0;
  int          last_wait;
  exp_t        exp_q[$];
  logic [31:0] rs_q[$];
  logic [3:0]  addr_q[$];

  // Reference model written straight from the operand2 rules.
  function automatic exp_t model(input bit imm, input logic [11:0] op2,
                                 input logic [31:0] rm, input bit c,
                                 input logic [31:0] rs);
    exp_t e;
    int rot, n, amt;
    e = '0;
    e.sc = c;
    e.chk_by = 1'b1;
    if (imm) begin
      rot = int'(op2[11:8]);
      e.shiftin = {24'd0, op2[7:0]};
      e.code = 2'd3;
      e.shiftby = 5'((rot * 2) % 32);
      if (rot == 0) begin
        e.byp = 1'b1; e.bval = {24'd0, op2[7:0]}; e.bc = c;
      end
    end else if (!op2[4]) begin
      n = int'(op2[11:7]);
      e.shiftin = rm;
      e.code = op2[6:5];
      e.shiftby = 5'(n);
      if (op2[6:5] == 2'd0 && n == 0) begin
        e.byp = 1'b1; e.bval = rm; e.bc = c;
      end
    end else begin
      amt = int'(rs[7:0]);
      e.shiftin = rm;
      e.code = op2[6:5];
      e.shiftby = 5'(amt % 32);
      if (amt == 0) begin
        e.byp = 1'b1; e.bval = rm; e.bc = c; e.chk_by = 1'b0;
      end else if (amt >= 32) begin
        case (op2[6:5])
          2'd0: begin e.byp = 1'b1; e.bc = (amt == 32) ? rm[0] : 1'b0; e.chk_by = 1'b0; end
          2'd1: begin e.byp = 1'b1; e.bc = (amt == 32) ? rm[31] : 1'b0; e.chk_by = 1'b0; end
          2'd2: e.shiftby = 5'd0;
          default: if (amt % 32 == 0) begin
            e.byp = 1'b1; e.bval = rm; e.bc = rm[31]; e.chk_by = 1'b0;
          end
        endcase
      end
    end
    return e;
  endfunction

  function automatic exp_t get_out();
    exp_t g;
    g.shiftin = bus.shiftin;
    g.shiftby = bus.shiftby;
    g.code    = bus.shiftcode;
    g.sc      = bus.shift_cflag;
    g.byp     = bus.bypass;
    g.bval    = bus.bypass_val;
    g.bc      = bus.bypass_carry;
    g.chk_by  = 1'b0;
    return g;
  endfunction

  // out_ready generator: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 4) != 0;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Register-file responder: answers each rs_req in order, garbage otherwise.
  initial begin
    logic [3:0] a;
    bus.rs_data = '0;
    forever begin
      @(negedge clk);
      if (bus.rs_req === 1'b1) begin
        n_checks++;
        if (rs_q.size() == 0) begin
          n_fail++;
          $display("FAIL rs_req_unexpected: got rs_req=1 addr=%0d, required no request", bus.rs_addr);
        end else begin
          bus.rs_data = rs_q.pop_front();
          a = addr_q.pop_front();
          if (bus.rs_addr !== a) begin
            n_fail++;
            $display("FAIL rs_addr: got %0d required %0d", bus.rs_addr, a);
          end
        end
      end else begin
        bus.rs_data = $urandom;
      end
    end
  end

  // Monitor: scoreboard pop on handshake, stability and in_ready under stall.
  initial begin
    exp_t held, g, e;
    bit hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          n_checks++;
          if (bus.out_valid !== 1'b1 || get_out() !== held) begin
            n_fail++;
            $display("FAIL stall_stable: got valid=%0b out=%h required valid=1 out=%h",
                     bus.out_valid, get_out(), held);
          end
        end
        hold_v = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        if (hold_v) begin
          held = get_out();
          n_checks++;
          if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_stall: got %0b required 0", bus.in_ready);
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          n_checks++;
          g = get_out();
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %h required none", g);
          end else begin
            e = exp_q.pop_front();
            if (!e.chk_by) g.shiftby = e.shiftby;
            g.chk_by = e.chk_by;
            n_txn++;
            if (g !== e) begin
              n_fail++;
              $display("FAIL result %0d: got shiftin=%h by=%0d code=%0d sc=%0b byp=%0b val=%h c=%0b required shiftin=%h by=%0d code=%0d sc=%0b byp=%0b val=%h c=%0b",
                       n_txn, g.shiftin, g.shiftby, g.code, g.sc, g.byp, g.bval, g.bc,
                       e.shiftin, e.shiftby, e.code, e.sc, e.byp, e.bval, e.bc);
            end else begin
              $display("txn %0d: shiftin=%h by=%0d code=%0d byp=%0b val=%h carry=%0b",
                       n_txn, g.shiftin, g.shiftby, g.code, g.byp, g.bval, g.bc);
            end
          end
        end
      end
    end
  end

  // Starts and ends at posedge+1. chk_lat also checks the accept-to-valid latency.
  task automatic send(input bit imm, input logic [11:0] op2, input logic [31:0] rm,
                      input bit c, input logic [31:0] rs, input bit chk_lat);
    bit is_reg, ok;
    is_reg = !imm && op2[4];
    bus.in_valid = 1'b1;
    bus.imm_flag = imm;
    bus.op2      = op2;
    bus.rm_val   = rm;
    bus.cflag    = c;
    last_wait = 0;
    do begin
      @(negedge clk);
      last_wait++;
    end while (bus.in_ready !== 1'b1 && last_wait < 200);
    ok = (bus.in_ready === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=%0b after %0d cycles, required 1", bus.in_ready, last_wait);
    end else begin
      exp_q.push_back(model(imm, op2, rm, c, rs));
      if (is_reg) begin
        rs_q.push_back(rs);
        addr_q.push_back(op2[11:8]);
      end
    end
    @(posedge clk); #1;
    if (chk_lat || !ok) begin
      bus.in_valid = 1'b0;
      bus.op2      = 12'($urandom);
      bus.rm_val   = $urandom;
      if (ok) begin
        @(negedge clk);
        if (is_reg) begin
          n_checks++;
          if (bus.rs_req !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_fetch_phase: got rs_req=%0b out_valid=%0b required 1/0", bus.rs_req, bus.out_valid);
          end
          @(posedge clk); #1;
          @(negedge clk);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.rs_req !== 1'b0) begin
          n_fail++;
          $display("FAIL latency: got out_valid=%0b rs_req=%0b required 1/0", bus.out_valid, bus.rs_req);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    rdy_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic check_idle_zero(input string name);
    exp_t z;
    z = '0;
    n_checks++;
    if (get_out() !== z || bus.out_valid !== 1'b0 || bus.rs_req !== 1'b0 ||
        bus.rs_addr !== 4'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got out=%h valid=%0b rs_req=%0b rs_addr=%0d in_ready=%0b required all 0, in_ready=1",
               name, get_out(), bus.out_valid, bus.rs_req, bus.rs_addr, bus.in_ready);
    end
  endtask

  initial begin
    logic [11:0] op2;
    logic [31:0] rs;
    bit imm;
    int form, pick;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.imm_flag = 1'b0;
    bus.op2      = '0;
    bus.rm_val   = '0;
    bus.cflag    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_zero("reset_state");
    @(posedge clk); #1;

    // Directed cases with downstream always ready.
    set_mode(0);
    send(1'b1, 12'h4FF, $urandom, 1'b1, 32'd0, 1'b1);
    send(1'b1, 12'h0AB, $urandom, 1'b1, 32'd0, 1'b1);
    send(1'b0, 12'h000, 32'h8000_0001, 1'b0, 32'd0, 1'b1);
    send(1'b0, 12'h020, 32'h8000_0001, 1'b0, 32'd0, 1'b1);
    send(1'b0, 12'h312, 32'h0000_0001, 1'b0, 32'd32, 1'b1);
    send(1'b0, 12'h312, 32'h0000_0001, 1'b0, 32'd33, 1'b1);
    send(1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h40, 1'b1);
    send(1'b0, 12'h270, 32'h8000_0000, 1'b0, 32'h44, 1'b1);
    send(1'b0, 12'h850, 32'h8000_0000, 1'b1, 32'h120, 1'b1);
    drain();

    // Back-to-back immediates: each must be accepted on its first cycle.
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 12'($urandom), $urandom, 1'($urandom), 32'd0, 1'b0);
      n_checks++;
      if (last_wait != 1) begin
        n_fail++;
        $display("FAIL back_to_back %0d: got accept after %0d cycles required 1", i, last_wait);
      end
    end
    bus.in_valid = 1'b0;
    drain();

    // Downstream stall for three cycles.
    set_mode(2);
    send(1'b1, 12'h3C5, $urandom, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall %0d: got in_ready=%0b out_valid=%0b required 0/1", i, bus.in_ready, bus.out_valid);
      end
    end
    @(posedge clk); #1;
    set_mode(0);
    drain();

    // Reset in the middle of an Rs fetch discards the operand.
    bus.in_valid = 1'b1;
    bus.imm_flag = 1'b0;
    bus.op2      = 12'h512;
    bus.rm_val   = $urandom;
    bus.cflag    = 1'b1;
    @(negedge clk);
    rs_q.push_back(32'd5);
    addr_q.push_back(4'd5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rs_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup: got rs_req=%0b required 1", bus.rs_req);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.rs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got out_valid=%0b rs_req=%0b required 0/0", bus.out_valid, bus.rs_req);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rs_q.delete();
    addr_q.delete();
    #1;
    check_idle_zero("reset_mid_fetch");
    repeat (2) @(negedge clk);
    check_idle_zero("fetch_discarded");
    @(posedge clk); #1;

    // Randomised traffic with random backpressure.
    set_mode(1);
    for (int i = 0; i < 300; i++) begin
      form = $urandom % 3;
      op2  = 12'($urandom);
      rs   = $urandom;
      imm  = (form == 0);
      if (form == 0 && ($urandom % 4) == 0) op2[11:8] = 4'd0;
      if (form == 1) begin
        op2[4] = 1'b0;
        if (($urandom % 4) == 0) op2[11:7] = 5'd0;
      end
      if (form == 2) begin
        op2[7] = 1'b0;
        op2[4] = 1'b1;
        pick = $urandom % 8;
        case (pick)
          0: rs[7:0] = 8'd0;
          1: rs[7:0] = 8'd32;
          2: rs[7:0] = 8'd33;
          3: rs[7:0] = 8'd64;
          4: rs[7:0] = 8'($urandom % 32);
          5: rs[7:0] = 8'(32 * ($urandom % 8) + ($urandom % 2));
          default: ;
        endcase
      end
      send(imm, op2, $urandom, 1'($urandom), rs, 1'($urandom));
    end
    bus.in_valid = 1'b0;
    set_mode(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
